audio_lr_mix_scheduler: RTL and testbench
=========================================

// Module: audio_lr_mix_scheduler
// PURPOSE
//  Sequences 32-bit stereo sample words ({L[31:16],R[15:0]}, signed 16-bit) to the codec serializer.
//  Arbitrates two producers onto the one output path: the CPU music stream from the LR-data PIO, and the hardware SFX engine.
//  Buffers each producer in a FIFO. On every codec frame tick it pops one word from each FIFO and mixes them with saturation.
//  Presents the mixed word to the serializer for the next LRCK frame.
// PARAMETERS
//  DEPTH  4  entries per source FIFO; power of 2, >=2
//  AW     2  log2(DEPTH); FIFO pointer width
// PORTS
//  clk           in   1   system clock
//  reset_n       in   1   asynchronous, active-low reset
//  music_data    in   32  music sample word {L,R}
//  music_valid   in   1   music_data valid this cycle
//  music_ready   out  1   music FIFO can accept a word
//  sfx_data      in   32  SFX sample word {L,R}
//  sfx_valid     in   1   sfx_data valid this cycle
//  sfx_ready     out  1   SFX FIFO can accept a word
//  mute_music    in   1   music contributes 0 to the mix; still popped
//  mute_sfx      in   1   SFX contributes 0 to the mix; still popped
//  frame_tick    in   1   1-cycle pulse from codec i/f, once per LRCK frame
//  out_lr        out  32  mixed sample word held for the serializer
//  out_valid     out  1   1-cycle pulse when out_lr updates
//  underrun_cnt  out  16  frames where the music FIFO was empty at tick; saturating
//  overrun_cnt   out  16  frame_ticks dropped while busy; saturating
// BEHAVIOUR
//  Reset values: FIFOs empty; music_ready=sfx_ready=0; out_lr=0; out_valid=0; both counters=0; FSM=IDLE.
//  ready outputs are registered: ready <= (next_count < DEPTH). They become 1 on the first clk after reset deasserts.
//  Push on valid&&ready. valid without ready is ignored; the producer holds data.
//  FSM, one state per cycle:
//    IDLE -> POP on frame_tick.
//    POP: latch each FIFO head, or 0 if that FIFO is empty; pop every non-empty FIFO. If music is empty, underrun_cnt++.
//    MIX: per channel, compute a 17-bit signed sum of the music and SFX halves after muting.
//         Clamp the sum to [-32768, +32767].
//    OUT: out_lr <= {Lsat,Rsat}; out_valid=1 for this cycle only. -> IDLE.
//  Latency: frame_tick at cycle T -> out_valid at T+3. out_lr holds its value until the next OUT.
//  frame_tick in POP/MIX/OUT: the tick is dropped and overrun_cnt++. It is not queued.
//  Empty-FIFO rules:
//    Empty SFX at a tick is normal: it contributes 0 and is not counted.
//    Empty music contributes 0, so the output is silence plus SFX.
//  Simultaneous push and pop on the same FIFO in POP: the pop uses the pre-cycle head.
//    The pushed word is appended; count is unchanged.
//    A push into an empty FIFO in the POP cycle is not popped that frame.
//  Full FIFO: ready=0; a push attempt has no effect and no data is lost.
//  Pointers wrap modulo DEPTH. count ranges 0..DEPTH and is held in AW+1 bits.
//  Counters stick at 16'hFFFF.
//  mute_* is sampled in the MIX cycle.
//  Asserting reset_n low mid-sequence: immediate return to the reset values; any in-flight pops are discarded.
// TESTING
//  1. Push music 0x1000_F000 and SFX 0x0800_0800, then a tick.
//     -> out_valid at T+3 with out_lr=0x1800_F800; underrun_cnt=0.
//  2. Music 0x7000_9000 + SFX 0x2000_E000.
//     -> out_lr=0x7FFF_8000 (positive and negative saturation).
//  3. Both FIFOs empty, tick -> out_lr=0x0000_0000; underrun_cnt=1.
//  4. Hold music_valid for 6 cycles with DEPTH=4 and no ticks.
//     -> 4 words accepted; music_ready=0 from the 5th cycle.
//     -> Then 4 ticks return the words in order; a 5th tick increments underrun_cnt.
//  5. Ticks at T and T+2 -> one out_valid at T+3; overrun_cnt=1.
//  6. Assert reset in the MIX state -> out_valid never fires.
//     -> All outputs at reset values; ready=1 one cycle after release.

Source files
------------

// File: rtl/audio_lr_mix_scheduler.sv
// Stereo mix scheduler: buffers a music stream and an SFX stream in small FIFOs,
// and on each codec frame tick pops one word from each and emits a saturated
// per-channel sum for the serializer.
module audio_lr_mix_scheduler #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] music_data,
    input  logic        music_valid,
    output logic        music_ready,
    input  logic [31:0] sfx_data,
    input  logic        sfx_valid,
    output logic        sfx_ready,
    input  logic        mute_music,
    input  logic        mute_sfx,
    input  logic        frame_tick,
    output logic [31:0] out_lr,
    output logic        out_valid,
    output logic [15:0] underrun_cnt,
    output logic [15:0] overrun_cnt
);

    typedef enum logic [1:0] {StIdle, StPop, StMix, StOut} state_e;

    localparam logic [AW:0] Full = DEPTH[AW:0];

    state_e state_q, state_d;

    logic [31:0]   music_mem [DEPTH];
    logic [31:0]   sfx_mem   [DEPTH];
    logic [AW-1:0] music_wr_q, music_rd_q, sfx_wr_q, sfx_rd_q;
    logic [AW:0]   music_cnt_q, music_cnt_d, sfx_cnt_q, sfx_cnt_d;
    logic          music_ready_q, sfx_ready_q;
    logic          music_push, music_pop, sfx_push, sfx_pop;
    logic [31:0]   music_head_q, sfx_head_q;
    logic [31:0]   music_mix, sfx_mix;
    logic [31:0]   out_lr_q;
    logic [15:0]   underrun_q, overrun_q;

    // Signed 16-bit add with clamping to the representable range.
    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {a[15], a} + {b[15], b};
        case (s[16:15])
            2'b01:   sat_add = 16'h7FFF;
            2'b10:   sat_add = 16'h8000;
            default: sat_add = s[15:0];
        endcase
    endfunction

    assign music_push = music_valid && music_ready_q;
    assign sfx_push   = sfx_valid && sfx_ready_q;
    // Emptiness is judged on the pre-cycle count, so a word pushed during POP waits a frame.
    assign music_pop  = (state_q == StPop) && (music_cnt_q != '0);
    assign sfx_pop    = (state_q == StPop) && (sfx_cnt_q != '0);

    // Next occupancy of both FIFOs.
    always_comb begin
        music_cnt_d = music_cnt_q;
        sfx_cnt_d   = sfx_cnt_q;
        if (music_push && !music_pop) music_cnt_d = music_cnt_q + 1'b1;
        else if (!music_push && music_pop) music_cnt_d = music_cnt_q - 1'b1;
        if (sfx_push && !sfx_pop) sfx_cnt_d = sfx_cnt_q + 1'b1;
        else if (!sfx_push && sfx_pop) sfx_cnt_d = sfx_cnt_q - 1'b1;
    end

    // FIFO storage; contents need no reset because the pointers gate every read.
    always_ff @(posedge clk) begin
        if (music_push) music_mem[music_wr_q] <= music_data;
        if (sfx_push) sfx_mem[sfx_wr_q] <= sfx_data;
    end

    // FIFO pointers, counts and registered ready flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            music_wr_q    <= '0;
            music_rd_q    <= '0;
            sfx_wr_q      <= '0;
            sfx_rd_q      <= '0;
            music_cnt_q   <= '0;
            sfx_cnt_q     <= '0;
            music_ready_q <= 1'b0;
            sfx_ready_q   <= 1'b0;
        end else begin
            if (music_push) music_wr_q <= music_wr_q + 1'b1;
            if (music_pop) music_rd_q <= music_rd_q + 1'b1;
            if (sfx_push) sfx_wr_q <= sfx_wr_q + 1'b1;
            if (sfx_pop) sfx_rd_q <= sfx_rd_q + 1'b1;
            music_cnt_q   <= music_cnt_d;
            sfx_cnt_q     <= sfx_cnt_d;
            music_ready_q <= (music_cnt_d < Full);
            sfx_ready_q   <= (sfx_cnt_d < Full);
        end
    end

    // Frame sequencer next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (frame_tick) state_d = StPop;
            StPop:   state_d = StMix;
            StMix:   state_d = StOut;
            StOut:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Muting is applied at mix time so the streams keep draining while muted.
    always_comb begin
        music_mix = mute_music ? 32'h0 : music_head_q;
        sfx_mix   = mute_sfx ? 32'h0 : sfx_head_q;
    end

    // Sequencer state, latched heads, output word and saturating counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            music_head_q <= '0;
            sfx_head_q   <= '0;
            out_lr_q     <= '0;
            underrun_q   <= '0;
            overrun_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StPop) begin
                music_head_q <= (music_cnt_q != '0) ? music_mem[music_rd_q] : 32'h0;
                sfx_head_q   <= (sfx_cnt_q != '0) ? sfx_mem[sfx_rd_q] : 32'h0;
                if (music_cnt_q == '0 && underrun_q != 16'hFFFF) underrun_q <= underrun_q + 1'b1;
            end
            // Written on the MIX->OUT edge so out_lr is already new while out_valid is high.
            if (state_q == StMix) begin
                out_lr_q <= {sat_add(music_mix[31:16], sfx_mix[31:16]),
                             sat_add(music_mix[15:0], sfx_mix[15:0])};
            end
            if (frame_tick && state_q != StIdle && overrun_q != 16'hFFFF) begin
                overrun_q <= overrun_q + 1'b1;
            end
        end
    end

    assign music_ready  = music_ready_q;
    assign sfx_ready    = sfx_ready_q;
    assign out_lr       = out_lr_q;
    assign out_valid    = (state_q == StOut);
    assign underrun_cnt = underrun_q;
    assign overrun_cnt  = overrun_q;

endmodule

// File: tb/tb_audio_lr_mix_scheduler.sv
// Scoreboard bench for audio_lr_mix_scheduler: ticks push the expected mixed word
// and its arrival cycle; a negedge monitor pops and compares on every out_valid.
module tb_audio_lr_mix_scheduler;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] music_data = '0;
    logic        music_valid = 1'b0;
    logic        music_ready;
    logic [31:0] sfx_data = '0;
    logic        sfx_valid = 1'b0;
    logic        sfx_ready;
    logic        mute_music = 1'b0;
    logic        mute_sfx = 1'b0;
    logic        frame_tick = 1'b0;
    logic [31:0] out_lr;
    logic        out_valid;
    logic [15:0] underrun_cnt;
    logic [15:0] overrun_cnt;

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          exp_underrun = 0;
    int          exp_overrun = 0;
    logic [31:0] exp_q [$];
    int          exp_cyc_q [$];
    logic [31:0] words [4];

    audio_lr_mix_scheduler #(.DEPTH(4), .AW(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .music_data   (music_data),
        .music_valid  (music_valid),
        .music_ready  (music_ready),
        .sfx_data     (sfx_data),
        .sfx_valid    (sfx_valid),
        .sfx_ready    (sfx_ready),
        .mute_music   (mute_music),
        .mute_sfx     (mute_sfx),
        .frame_tick   (frame_tick),
        .out_lr       (out_lr),
        .out_valid    (out_valid),
        .underrun_cnt (underrun_cnt),
        .overrun_cnt  (overrun_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc > 20000) begin
            $display("FAIL watchdog: cycle %0d, required finish before 20000", cyc);
            $fatal(1, "watchdog");
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every out_valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                check("out_lr", out_lr, exp_q.pop_front());
                check("out_latency", 32'(cyc), 32'(exp_cyc_q.pop_front()));
            end
        end
    end

    task automatic push_music(input logic [31:0] w);
        int n = 0;
        @(negedge clk);
        music_data  = w;
        music_valid = 1'b1;
        while (!music_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!music_ready) check("music_push_timeout", 32'd0, 32'd1);
        @(negedge clk);
        music_valid = 1'b0;
    endtask

    task automatic push_sfx(input logic [31:0] w);
        int n = 0;
        @(negedge clk);
        sfx_data  = w;
        sfx_valid = 1'b1;
        while (!sfx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!sfx_ready) check("sfx_push_timeout", 32'd0, 32'd1);
        @(negedge clk);
        sfx_valid = 1'b0;
    endtask

    // Issue one tick, expect `w` three cycles later, then let the frame finish.
    task automatic tick(input logic [31:0] w);
        @(negedge clk);
        frame_tick = 1'b1;
        exp_q.push_back(w);
        exp_cyc_q.push_back(cyc + 3);
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_underrun"}, 32'(underrun_cnt), 32'(exp_underrun));
        check({tag, "_overrun"}, 32'(overrun_cnt), 32'(exp_overrun));
    endtask

    initial begin
        int idx;
        // Reset state
        #2;
        check("rst_music_ready", 32'(music_ready), 32'd0);
        check("rst_sfx_ready", 32'(sfx_ready), 32'd0);
        check("rst_out_lr", out_lr, 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check_counters("rst");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check("ready_before_clk", 32'(music_ready), 32'd0);
        @(negedge clk);
        check("ready_after_clk", 32'({music_ready, sfx_ready}), 32'd3);

        // 1: basic mix
        push_music(32'h1000_F000);
        push_sfx(32'h0800_0800);
        tick(32'h1800_F800);
        check_counters("t1");

        // 2: positive and negative saturation
        push_music(32'h7000_9000);
        push_sfx(32'h2000_E000);
        tick(32'h7FFF_8000);

        // 3: both empty -> silence and an underrun
        tick(32'h0000_0000);
        exp_underrun++;
        check_counters("t3");

        // Mutes zero a source but still pop it
        push_music(32'h1234_5678);
        push_sfx(32'h0001_0001);
        mute_music = 1'b1;
        tick(32'h0001_0001);
        mute_music = 1'b0;
        push_music(32'h4000_C000);
        push_sfx(32'h7000_9000);
        mute_sfx = 1'b1;
        tick(32'h4000_C000);
        mute_sfx = 1'b0;
        check_counters("mute");

        // 4: fill music FIFO, ready drops after DEPTH words
        words[0] = 32'h0001_0002;
        words[1] = 32'h0003_0004;
        words[2] = 32'hFFFF_FFFE;
        words[3] = 32'h7FFF_8000;
        idx = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            music_data  = words[idx < 4 ? idx : 3];
            music_valid = 1'b1;
            check($sformatf("fill_ready_%0d", k), 32'(music_ready), (k < 4) ? 32'd1 : 32'd0);
            if (music_ready) idx++;
        end
        @(negedge clk);
        music_valid = 1'b0;
        check("fill_accepted", 32'(idx), 32'd4);
        for (int k = 0; k < 4; k++) tick(words[k]);
        tick(32'h0);
        exp_underrun++;
        check_counters("t4");

        // Push into an empty FIFO during POP is not popped in that frame
        @(negedge clk);
        frame_tick = 1'b1;
        exp_q.push_back(32'h0);
        exp_cyc_q.push_back(cyc + 3);
        @(negedge clk);
        frame_tick  = 1'b0;
        music_data  = 32'h0ABC_0DEF;
        music_valid = 1'b1;
        @(negedge clk);
        music_valid = 1'b0;
        repeat (4) @(negedge clk);
        exp_underrun++;
        tick(32'h0ABC_0DEF);
        check_counters("pop_push");

        // 5: tick while busy is dropped and counted
        push_music(32'h0100_0100);
        push_sfx(32'h0002_FFFE);
        @(negedge clk);
        frame_tick = 1'b1;
        exp_q.push_back(32'h0102_00FE);
        exp_cyc_q.push_back(cyc + 3);
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (5) @(negedge clk);
        exp_overrun++;
        check_counters("t5");

        // 6: reset during MIX discards the frame
        push_music(32'h1111_2222);
        push_sfx(32'h3333_4444);
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("r6_out_lr", out_lr, 32'h0);
        check("r6_out_valid", 32'(out_valid), 32'd0);
        check("r6_ready", 32'({music_ready, sfx_ready}), 32'd0);
        exp_underrun = 0;
        exp_overrun  = 0;
        check_counters("r6");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check("r6_ready_before_clk", 32'(music_ready), 32'd0);
        @(negedge clk);
        check("r6_ready_after_clk", 32'({music_ready, sfx_ready}), 32'd3);
        // FIFOs were flushed: next frame is silence with an underrun
        tick(32'h0);
        exp_underrun++;
        check_counters("r6_post");

        repeat (6) @(negedge clk);
        check("outstanding_expectations", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
